// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the exhaustive truth-table sweep checker.
package tt_sweep_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: counts while enabled, tc on the last settle cycle.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iClr,
    input  logic iEn,
    output logic oTc
);

    logic [VEC_W-1:0] count_q;
    logic [VEC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (iClr) begin
            count_d = '0;
        end else if (iEn) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oTc = (count_q == VEC_W'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 {A,B,C,D} vectors into a 4-input block and checks its Y
// against a 16-bit expected truth table.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXPECTED = 16'h0000,
    parameter int                 SETTLE   = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iY,
    output logic             oA,
    output logic             oB,
    output logic             oC,
    output logic             oD,
    output logic             oBusy,
    output logic             oDone,
    output logic             oPass,
    output logic [ERR_W-1:0] oErrCnt,
    output logic [VEC_W-1:0] oFirstErr,
    output logic             oErrValid
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0]   first_err_q, first_err_d;
    logic               err_valid_q, err_valid_d;

    logic               tc;
    logic               mismatch;
    logic [ERR_W-1:0]   err_nxt;

    tt_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iClr  ((state_q != S_SETTLE) || tc),
        .iEn   (state_q == S_SETTLE),
        .oTc   (tc)
    );

    assign mismatch = (iY != EXPECTED[vec_q]);
    assign err_nxt  = err_cnt_q + ERR_W'(mismatch);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d     = S_SETTLE;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_valid_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (tc) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_cnt_d = err_nxt;
                if (mismatch && !err_valid_q) begin
                    first_err_d = vec_q;
                    err_valid_d = 1'b1;
                end
                if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                    // Drop the vector back to 0000 so IDLE sees all-zero inputs.
                    state_d = S_DONE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nxt == '0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign oA        = vec_q[3];
    assign oB        = vec_q[2];
    assign oC        = vec_q[1];
    assign oD        = vec_q[0];
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oPass     = pass_q;
    assign oErrCnt   = err_cnt_q;
    assign oFirstErr = first_err_q;
    assign oErrValid = err_valid_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboarded random bench for two checker instances (SETTLE = 1 and 3).
module tb_tt_sweep_checker;

    function automatic logic [15:0] tt_of();
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            v    = 4'(k);
            t[k] = (v[3] & v[2]) | (v[1] ^ v[0]);
        end
        return t;
    endfunction

    localparam logic [15:0] TT = tt_of();

    typedef struct {
        int         start;
        logic [4:0] cnt;
        logic [3:0] first;
        logic       valid;
        logic       pass;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] fault;
    int          cyc;
    int          ncmp;
    int          nfail;
    exp_t        q[2][$];
    int          busy_n[2];

    wire [3:0] v1, v3;
    wire       y1, y3;
    wire       busy1, done1, pass1, ev1;
    wire       busy3, done3, pass3, ev3;
    wire [4:0] cnt1, cnt3;
    wire [3:0] fe1, fe3;

    // Block under check: the reference function with selected rows inverted.
    assign y1 = TT[v1] ^ fault[v1];
    assign y3 = TT[v3] ^ fault[v3];

    tt_sweep_checker #(.EXPECTED(TT), .SETTLE(1)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iY(y1),
        .oA(v1[3]), .oB(v1[2]), .oC(v1[1]), .oD(v1[0]),
        .oBusy(busy1), .oDone(done1), .oPass(pass1),
        .oErrCnt(cnt1), .oFirstErr(fe1), .oErrValid(ev1)
    );

    tt_sweep_checker #(.EXPECTED(TT), .SETTLE(3)) u_dut3 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iY(y3),
        .oA(v3[3]), .oB(v3[2]), .oC(v3[1]), .oD(v3[0]),
        .oBusy(busy3), .oDone(done3), .oPass(pass3),
        .oErrCnt(cnt3), .oFirstErr(fe3), .oErrValid(ev3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input int s, input logic busy,
                       input logic done, input logic [3:0] v,
                       input logic [4:0] cnt, input logic [3:0] first,
                       input logic valid, input logic pass);
        int k;
        if (q[id].size() == 0) begin
            chk($sformatf("idle_busy%0d", s), int'(busy | done), 0);
            return;
        end
        k = cyc - q[id][0].start + 1;
        if (busy) begin
            busy_n[id]++;
            chk($sformatf("vec_s%0d", s), int'(v), (k - 1) / (s + 1));
            if (k == 1) begin
                chk($sformatf("clear_s%0d", s),
                    int'({cnt, valid, pass}), 0);
            end
        end
        if (done) begin
            chk($sformatf("done_cycle_s%0d", s), k, 16 * (s + 1) + 1);
            chk($sformatf("busy_len_s%0d", s), busy_n[id], 16 * (s + 1));
            chk($sformatf("errcnt_s%0d", s), int'(cnt), int'(q[id][0].cnt));
            chk($sformatf("errvalid_s%0d", s), int'(valid),
                int'(q[id][0].valid));
            chk($sformatf("pass_s%0d", s), int'(pass), int'(q[id][0].pass));
            if (q[id][0].valid) begin
                chk($sformatf("firsterr_s%0d", s), int'(first),
                    int'(q[id][0].first));
            end
            void'(q[id].pop_front());
            busy_n[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, 1, busy1, done1, v1, cnt1, fe1, ev1, pass1);
            mon(1, 3, busy3, done3, v3, cnt3, fe3, ev3, pass3);
        end
    end

    task automatic start_sweep(input logic [15:0] f);
        exp_t e;
        @(negedge clk);
        fault   = f;
        start   = 1'b1;
        e.start = cyc + 1;
        e.cnt   = 5'($countones(f));
        e.valid = (f != 0);
        e.pass  = (f == 0);
        e.first = '0;
        for (int i = 15; i >= 0; i--) begin
            if (f[i]) e.first = 4'(i);
        end
        q[0].push_back(e);
        q[1].push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (q[0].size() != 0 || q[1].size() != 0);
             i++) begin
            @(negedge clk);
        end
        if (q[0].size() != 0 || q[1].size() != 0) begin
            chk("timeout", 1, 0);
            q[0].delete();
            q[1].delete();
            busy_n[0] = 0;
            busy_n[1] = 0;
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_s1"},
            int'({busy1, done1, pass1, cnt1, fe1, ev1, v1}), 0);
        chk({name, "_s3"},
            int'({busy3, done3, pass3, cnt3, fe3, ev3, v3}), 0);
    endtask

    logic [15:0] r;

    initial begin
        cyc   = 0;
        ncmp  = 0;
        nfail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        fault = '0;
        busy_n[0] = 0;
        busy_n[1] = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        start_sweep(16'h0000);
        wait_idle();
        start_sweep(16'h0020);
        wait_idle();
        start_sweep(16'hFFFF);
        wait_idle();

        // Start pulse mid-sweep must be ignored.
        start_sweep(16'h0840);
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-sweep, then a fresh clean sweep.
        start_sweep(16'h1234);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        q[0].delete();
        q[1].delete();
        busy_n[0] = 0;
        busy_n[1] = 0;
        rst_n = 1'b1;
        start_sweep(16'h0000);
        wait_idle();

        for (int n = 0; n < 8; n++) begin
            r = 16'($urandom);
            if (n % 2 == 0) r = r & 16'($urandom) & 16'($urandom);
            start_sweep(r);
            wait_idle();
        end
        start_sweep(16'h8000);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Sequential stimulus-and-check stage that sits directly upstream of the 4-input combinational logic block (inputs A..D, output Y). On a start pulse it sweeps all 16 input combinations onto the block's inputs and samples the block's Y after a programmable settle time. It compares each sample against a 16-bit expected truth table and reports pass/fail, error count and first failing vector. This is the on-chip replacement for the exhaustive 0000..1111 simulation sweep.

## Interface
- EXPECTED, 16'h0000: expected Y per vector; bit k = expected Y when {A,B,C,D} = k (A is MSB).
- SETTLE, 1: cycles the vector is held before sampling; legal range 1..15.
- iClk  in  1  single clock, rising edge.
- iRst_n  in  1  reset; synchronous, active-low; sampled on the rising edge of iClk.
- iStart  in  1  start pulse; honoured only in IDLE.
- iY  in  1  output of the block under check.
- oA, oB, oC, oD  out  1 each  drive the block's A..D inputs; registered.
- oBusy  out  1  high from the first SETTLE cycle through the last CHECK cycle.
- oDone  out  1  one-cycle pulse at end of sweep.
- oPass  out  1  1 when oErrCnt == 0 at end of sweep; held until next start.
- oErrCnt  out  5  number of mismatching vectors, 0..16.
- oFirstErr  out  4  index of lowest failing vector; valid only when oErrValid = 1.
- oErrValid  out  1  at least one mismatch recorded in current or last sweep.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - oA..oD = 0000.
  - iStart = 1 → SETTLE with vec = 0 and settle counter = 0.
  - Clears oErrCnt, oErrValid, oFirstErr and oPass.
- SETTLE:
  - {oA,oB,oC,oD} = vec.
  - Counter increments each cycle; when counter == SETTLE-1 → CHECK.
- CHECK:
  - Samples iY at the closing edge.
  - If iY != EXPECTED[vec]: oErrCnt += 1; if oErrValid was 0, set oFirstErr = vec and oErrValid = 1.
  - If vec == 15 → DONE; else vec += 1, counter = 0 → SETTLE.
- DONE: oDone = 1 and oPass updated for this one cycle, then → IDLE.
- vec is 4 bits and never wraps during a run; the run ends at 15.
- oErrCnt is 5 bits and cannot overflow (max 16).
- iStart while busy or in DONE: ignored; no restart, no result clear.
- iStart held high: a new sweep starts on each return to IDLE.

## Timing
- Reset (iRst_n = 0 at an edge), from any state including mid-sweep:
  - State = IDLE, vec = 0, counter = 0.
  - oA..oD = 0, oBusy = 0, oDone = 0, oPass = 0, oErrCnt = 0, oFirstErr = 0, oErrValid = 0.
- Reset takes priority over iStart on the same edge.
- iStart sampled at edge N → vector 0 is on oA..oD and oBusy = 1 after edge N.
- Each vector occupies SETTLE + 1 cycles: SETTLE cycles in SETTLE, 1 cycle in CHECK.
- Sweep length is 16·(SETTLE+1) busy cycles, followed by 1 DONE cycle.
- oDone asserts during cycle 16·(SETTLE+1)+1 after the start edge.
- oErrCnt, oFirstErr and oErrValid update at the CHECK closing edge, so they are visible one cycle after the sample.
- All outputs are registered; no combinational path from iY to any output.

## Structure
- Shared package tt_sweep_pkg:
  - state enum localparams S_IDLE, S_SETTLE, S_CHECK, S_DONE;
  - VEC_W = 4, NUM_VEC = 16, ERR_W = 5.
- One sub-module, tt_settle_timer: 4-bit counter with clear and terminal-count output (tc when count == SETTLE-1).
- FSM, vector register and result registers stay in the top module.

## Test plan
- SETTLE = 1, EXPECTED = the block's true function, correct DUT on iY → oDone at cycle 33 after start; oPass = 1, oErrCnt = 0, oErrValid = 0.
- Same setup, DUT row 5 (0101) forced inverted → oErrCnt = 1, oFirstErr = 5, oErrValid = 1, oPass = 0.
- EXPECTED = bitwise inverse of DUT function → oErrCnt = 16, oFirstErr = 0, oPass = 0.
- SETTLE = 3 → each vector held 3 cycles, then CHECK; oA..oD steps 0000→1111; oDone at cycle 65; oBusy high for exactly 64 cycles.
- iStart pulsed at vector 7 mid-sweep → ignored; results identical to an uninterrupted run.
- iRst_n = 0 at vector 7 → all outputs zero at next edge, state IDLE; a fresh iStart produces a clean full sweep with correct results.
